// File: rtl/sram_template_2p_if.sv
// sram_template_2p_if: read/write request and response bundle between a cache stage and its array.
interface sram_template_2p_if #(
    parameter int ADDR_W = 8,
    parameter int WAYS = 8,
    parameter int WAY_W = 20
);
    logic                     io_r_req_valid;
    logic                     io_r_req_ready;
    logic [ADDR_W-1:0]        io_r_addr;
    logic                     io_r_resp_valid;
    logic [WAYS*WAY_W-1:0]    io_r_data;
    logic                     io_w_req_valid;
    logic                     io_w_req_ready;
    logic [ADDR_W-1:0]        io_w_addr;
    logic [WAYS*WAY_W-1:0]    io_w_data;
    logic [WAYS-1:0]          io_w_mask;
    logic                     io_init_done;
    modport master (
        output io_r_req_valid, io_r_addr, io_w_req_valid, io_w_addr, io_w_data, io_w_mask,
        input  io_r_req_ready, io_r_resp_valid, io_r_data, io_w_req_ready, io_init_done
    );
    modport slave (
        input  io_r_req_valid, io_r_addr, io_w_req_valid, io_w_addr, io_w_data, io_w_mask,
        output io_r_req_ready, io_r_resp_valid, io_r_data, io_w_req_ready, io_init_done
    );
endinterface

// File: rtl/sram_template_2p.sv
// sram_template_2p: 1R+1W set-associative row array with per-way write mask,
// registered read response, optional write-to-read bypass and post-reset clear sweep.
module sram_template_2p #(
    parameter int SETS = 256,
    parameter int ADDR_W = 8,
    parameter int WAYS = 8,
    parameter int WAY_W = 20,
    parameter bit HOLD_READ = 1,
    parameter bit BYPASS = 1,
    parameter bit RESET_CLEAR = 1
) (
    input logic clock,
    input logic reset,
    sram_template_2p_if.slave io
);
    localparam int ROW_W = WAYS * WAY_W;
    typedef enum logic {INIT, IDLE} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ROW_W-1:0] mem [SETS];
    logic [ROW_W-1:0] bit_mask, merged, rd_row, r_data;
    logic r_valid, ready, rd_fire, wr_fire, same;

    assign ready = state == IDLE;
    assign rd_fire = io.io_r_req_valid && ready;
    assign wr_fire = io.io_w_req_valid && ready;
    assign io.io_r_req_ready = ready;
    assign io.io_w_req_ready = ready;
    assign io.io_init_done = ready;
    assign io.io_r_resp_valid = r_valid;
    assign io.io_r_data = r_data;

    for (genvar i = 0; i < WAYS; i++) begin : g_mask
        assign bit_mask[i*WAY_W +: WAY_W] = {WAY_W{io.io_w_mask[i]}};
    end

    // Same-set bypass reuses the write merge so the response sees the post-write row.
    assign merged = (mem[io.io_w_addr] & ~bit_mask) | (io.io_w_data & bit_mask);
    assign same = BYPASS && wr_fire && io.io_w_addr == io.io_r_addr;
    assign rd_row = same ? merged : mem[io.io_r_addr];

    always_comb begin
        state_nxt = state;
        state_nxt = (state == INIT && (!RESET_CLEAR || cnt == ADDR_W'(SETS - 1))) ? IDLE : state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt <= '0;
            r_valid <= 1'b0;
            r_data <= '0;
        end else begin
            state <= state_nxt;
            cnt <= (state == INIT) ? cnt + 1'b1 : cnt;
            r_valid <= rd_fire;
            if (rd_fire || !HOLD_READ) r_data <= rd_row;
        end
    end

    // Storage has no reset; the sweep zeroes it row by row instead.
    always_ff @(posedge clock) begin
        if (state == INIT && RESET_CLEAR) mem[cnt] <= '0;
        else if (wr_fire) mem[io.io_w_addr] <= merged;
    end
endmodule

// File: tb/tb_sram_template_2p.sv
// tb_sram_template_2p: directed vectors with a scoreboard per instance (bypass/hold and read-first/no-hold).
module tb_sram_template_2p;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [159:0] q1 [$];
    logic [159:0] q2 [$];

    always #5 clock = ~clock;

    sram_template_2p_if io ();
    sram_template_2p_if io2 ();

    assign io2.io_r_req_valid = io.io_r_req_valid;
    assign io2.io_r_addr = io.io_r_addr;
    assign io2.io_w_req_valid = io.io_w_req_valid;
    assign io2.io_w_addr = io.io_w_addr;
    assign io2.io_w_data = io.io_w_data;
    assign io2.io_w_mask = io.io_w_mask;

    sram_template_2p dut (.clock(clock), .reset(reset), .io(io.slave));
    sram_template_2p #(.BYPASS(1'b0), .HOLD_READ(1'b0)) dut2 (.clock(clock), .reset(reset), .io(io2.slave));

    function automatic logic [159:0] row(logic [19:0] lo, logic [19:0] hi, logic [7:0] m);
        logic [159:0] r;
        for (int i = 0; i < 8; i++) r[i*20 +: 20] = m[i] ? lo : hi;
        return r;
    endfunction

    task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(logic [7:0] a, logic [159:0] e1, logic [159:0] e2);
        io.io_r_req_valid = 1'b1;
        io.io_r_addr = a;
        q1.push_back(e1);
        q2.push_back(e2);
    endtask

    task automatic wr(logic [7:0] a, logic [19:0] d, logic [7:0] m);
        io.io_w_req_valid = 1'b1;
        io.io_w_addr = a;
        io.io_w_data = row(d, d, 8'hFF);
        io.io_w_mask = m;
    endtask

    task automatic idle();
        io.io_r_req_valid = 1'b0;
        io.io_w_req_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset && io.io_r_resp_valid) begin
            if (q1.size() == 0) chk("unexpected_resp1", 160'd1, 160'd0);
            else chk("resp1", io.io_r_data, q1.pop_front());
        end
        if (!reset && io2.io_r_resp_valid) begin
            if (q2.size() == 0) chk("unexpected_resp2", 160'd1, 160'd0);
            else chk("resp2", io2.io_r_data, q2.pop_front());
        end
    end

    initial begin
        logic [159:0] held;
        idle();
        io.io_r_addr = '0;
        io.io_w_addr = '0;
        io.io_w_data = '0;
        io.io_w_mask = '0;
        repeat (3) cyc();
        @(negedge clock);
        chk("rst_resp_valid", 160'(io.io_r_resp_valid), 160'd0);
        chk("rst_r_data", io.io_r_data, 160'd0);
        chk("rst_ready", 160'({io.io_r_req_ready, io.io_w_req_ready, io.io_init_done}), 160'd0);
        cyc();
        reset = 1'b0;
        repeat (255) cyc();
        @(negedge clock);
        chk("sweep_busy_255", 160'({io.io_r_req_ready, io.io_w_req_ready, io.io_init_done}), 160'd0);
        cyc();
        @(negedge clock);
        chk("sweep_done_256", 160'({io.io_r_req_ready, io.io_w_req_ready, io.io_init_done}), 160'd7);
        chk("sweep_done_dut2", 160'(io2.io_init_done), 160'd1);
        cyc();
        rd(8'd0, '0, '0); cyc();
        rd(8'd128, '0, '0); cyc();
        rd(8'd255, '0, '0); cyc();
        idle();
        wr(8'd5, 20'hAAAAA, 8'hFF); cyc();
        idle();
        rd(8'd5, row(20'hAAAAA, 20'hAAAAA, 8'hFF), row(20'hAAAAA, 20'hAAAAA, 8'hFF)); cyc();
        idle();
        wr(8'd5, 20'h55555, 8'h0F); cyc();
        idle();
        rd(8'd5, row(20'h55555, 20'hAAAAA, 8'h0F), row(20'h55555, 20'hAAAAA, 8'h0F)); cyc();
        idle();
        wr(8'd9, 20'h11111, 8'hFF); cyc();
        wr(8'd9, 20'h22222, 8'h01);
        rd(8'd9, row(20'h22222, 20'h11111, 8'h01), row(20'h11111, 20'h11111, 8'hFF)); cyc();
        idle();
        rd(8'd9, row(20'h22222, 20'h11111, 8'h01), row(20'h22222, 20'h11111, 8'h01)); cyc();
        wr(8'd6, 20'h12345, 8'hFF);
        rd(8'd5, row(20'h55555, 20'hAAAAA, 8'h0F), row(20'h55555, 20'hAAAAA, 8'h0F)); cyc();
        idle();
        held = row(20'h55555, 20'hAAAAA, 8'h0F);
        @(negedge clock);
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            chk("hold_data", io.io_r_data, held);
            chk("hold_no_valid", 160'(io.io_r_resp_valid), 160'd0);
        end
        rd(8'd6, row(20'h12345, 20'h12345, 8'hFF), row(20'h12345, 20'h12345, 8'hFF)); cyc();
        idle();
        cyc();
        reset = 1'b1; cyc(); cyc();
        reset = 1'b0;
        repeat (100) cyc();
        reset = 1'b1; cyc(); cyc();
        reset = 1'b0;
        repeat (10) cyc();
        io.io_w_req_valid = 1'b1;
        io.io_w_addr = 8'd3;
        io.io_w_data = '1;
        io.io_w_mask = 8'hFF;
        io.io_r_req_valid = 1'b1;
        io.io_r_addr = 8'd3;
        repeat (5) cyc();
        idle();
        repeat (240) cyc();
        @(negedge clock);
        chk("resweep_busy_255", 160'(io.io_init_done), 160'd0);
        cyc();
        @(negedge clock);
        chk("resweep_done_256", 160'(io.io_init_done), 160'd1);
        cyc();
        rd(8'd3, '0, '0); cyc();
        rd(8'd5, '0, '0); cyc();
        rd(8'd9, '0, '0); cyc();
        idle();
        repeat (3) cyc();
        chk("q1_drained", 160'(q1.size()), 160'd0);
        chk("q2_drained", 160'(q2.size()), 160'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
